csa_accum_pipe: RTL and testbench



---
 rtl/csa_accum_pipe.sv | 131 +++++++++++++
 tb/tb_csa_accum_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_pipe.sv
// csa_accum_pipe: streaming carry-save accumulator.
// Each accepted beat folds LANES operands into a running carry-save pair.
// A packet of one or more beats produces one redundant (C, S) result.
// Optional build macro CSA_ACCUM_RESOLVE_EN adds a resolved out_sum port.
// The resolved sum comes from a carry-propagate adder placed before the
// output register.
module csa_accum_pipe #(
    parameter int WIDTH = 19,
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_c,
    output logic [WIDTH-1:0]       out_s,
    output logic [CNT_W-1:0]       out_beats
`ifdef CSA_ACCUM_RESOLVE_EN
    ,
    output logic [WIDTH-1:0]       out_sum
`endif
);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_c_q, acc_s_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept, drain, base_zero;
    logic [WIDTH-1:0] c_d, s_d;
    logic [WIDTH-1:0] lane, maj, sum_t;
    logic [CNT_W-1:0] cnt_d;
`ifdef CSA_ACCUM_RESOLVE_EN
    logic [WIDTH-1:0] sum_d;
`endif

    // The output slot frees up when it is empty or is being drained this cycle.
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    // A new packet starts on in_first, or on any beat that arrives while idle.
    assign base_zero = in_first | (state_q == IDLE);

    // Compress the base pair and each lane through a chain of 3:2 compressors.
    // Each carry is shifted left and its top bit dropped, so c_d[0] stays 0.
    always_comb begin
        // NOTE: every variable gets a value before any branch or loop, so no latch is inferred.
        c_d   = base_zero ? '0 : acc_c_q;
        s_d   = base_zero ? '0 : acc_s_q;
        lane  = '0;
        maj   = '0;
        sum_t = '0;
        for (int i = 0; i < LANES; i++) begin
            lane  = in_data[i*WIDTH +: WIDTH];
            maj   = (c_d & s_d) | (c_d & lane) | (s_d & lane);
            sum_t = c_d ^ s_d ^ lane;
            c_d   = {maj[WIDTH-2:0], 1'b0};
            s_d   = sum_t;
        end
    end

    // The beat count restarts at 1 with each new packet and saturates at all-ones.
    always_comb begin
        if (base_zero) begin
            cnt_d = CNT_W'(1);
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef CSA_ACCUM_RESOLVE_EN
    // Resolve the redundant pair ahead of the output register.
    assign sum_d = c_d + s_d;
`endif

    // Hold the packet state and the output registers. Reset takes priority over any handshake.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            acc_c_q   <= '0;
            acc_s_q   <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_c     <= '0;
            out_s     <= '0;
            out_beats <= '0;
`ifdef CSA_ACCUM_RESOLVE_EN
            out_sum   <= '0;
`endif
        end else begin
            // A drain with no new result empties the slot and leaves the data as it was.
            if (drain) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (in_last) begin
                    out_c     <= c_d;
                    out_s     <= s_d;
                    out_beats <= cnt_d;
                    out_valid <= 1'b1;
`ifdef CSA_ACCUM_RESOLVE_EN
                    out_sum   <= sum_d;
`endif
                    acc_c_q   <= '0;
                    acc_s_q   <= '0;
                    cnt_q     <= '0;
                    state_q   <= IDLE;
                end else begin
                    acc_c_q   <= c_d;
                    acc_s_q   <= s_d;
                    cnt_q     <= cnt_d;
                    state_q   <= ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_accum_pipe.sv
// Directed bench for csa_accum_pipe.
// The main instance uses WIDTH=19, LANES=4 and CNT_W=8.
// A second instance with CNT_W=2 shares the same stimulus and checks counter saturation.
// The out_sum checks are included when CSA_ACCUM_RESOLVE_EN is defined.
module tb_csa_accum_pipe;

    localparam int W = 19;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [L*W-1:0] in_data;
    logic         in_first, in_last;
    logic         out_ready;

    logic         in_ready, out_valid;
    logic [W-1:0] out_c, out_s;
    logic [7:0]   out_beats;
    logic         in_ready2, out_valid2;
    logic [W-1:0] out_c2, out_s2;
    logic [1:0]   out_beats2;
`ifdef CSA_ACCUM_RESOLVE_EN
    logic [W-1:0] out_sum, out_sum2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    csa_accum_pipe #(.WIDTH(W), .LANES(L), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .out_s(out_s), .out_beats(out_beats)
`ifdef CSA_ACCUM_RESOLVE_EN
        , .out_sum(out_sum)
`endif
    );

    csa_accum_pipe #(.WIDTH(W), .LANES(L), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_c(out_c2),
        .out_s(out_s2), .out_beats(out_beats2)
`ifdef CSA_ACCUM_RESOLVE_EN
        , .out_sum(out_sum2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] rsum(input logic [W-1:0] c, input logic [W-1:0] s);
        return c + s;
    endfunction

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for a single edge, then deassert valid.
    task automatic beat(input logic [W-1:0] l0, input logic [W-1:0] l1,
                        input logic [W-1:0] l2, input logic [W-1:0] l3,
                        input logic f, input logic l);
        in_data  = {l3, l2, l1, l0};
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] hold_c, hold_s;
        int           pulses;

        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_c", 32'(out_c), 32'd0);
        check("rst_out_s", 32'(out_s), 32'd0);
        check("rst_out_beats", 32'(out_beats), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // Test 1: single-beat packet with lanes 1 to 4.
        beat(19'd1, 19'd2, 19'd3, 19'd4, 1'b1, 1'b1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(rsum(out_c, out_s)), 32'd10);
        check("t1_c0", 32'(out_c[0]), 32'd0);
        check("t1_beats", 32'(out_beats), 32'd1);
`ifdef CSA_ACCUM_RESOLVE_EN
        check("t1_out_sum", 32'(out_sum), 32'd10);
`endif
        tick();
        check("t1_drained", 32'(out_valid), 32'd0);

        // Test 2: four beats of all-ones lanes. out_valid must pulse once.
        pulses = 0;
        beat(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b1, 1'b0);
        pulses += int'(out_valid);
        beat(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b0, 1'b0);
        pulses += int'(out_valid);
        beat(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b0, 1'b0);
        pulses += int'(out_valid);
        beat(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b0, 1'b1);
        pulses += int'(out_valid);
        check("t2_sum", 32'(rsum(out_c, out_s)), 32'h7FFF0);
        check("t2_c0", 32'(out_c[0]), 32'd0);
        check("t2_beats", 32'(out_beats), 32'd4);
`ifdef CSA_ACCUM_RESOLVE_EN
        check("t2_out_sum", 32'(out_sum), 32'h7FFF0);
`endif
        tick();
        pulses += int'(out_valid);
        check("t2_valid_pulses", 32'(pulses), 32'd1);

        // Test 3: backpressure. A sum-10 result is held while a sum-6 beat waits.
        out_ready = 1'b0;
        beat(19'd1, 19'd2, 19'd3, 19'd4, 1'b1, 1'b1);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_sum10", 32'(rsum(out_c, out_s)), 32'd10);
        hold_c = out_c;
        hold_s = out_s;
        in_data = {19'd2, 19'd2, 19'd1, 19'd1};
        in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_in_ready_low", 32'(in_ready), 32'd0);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_c", 32'(out_c), 32'(hold_c));
            check("t3_hold_s", 32'(out_s), 32'(hold_s));
        end
        out_ready = 1'b1;
        #1;
        check("t3_in_ready_comb", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_new_valid", 32'(out_valid), 32'd1);
        check("t3_sum6", 32'(rsum(out_c, out_s)), 32'd6);
        check("t3_beats", 32'(out_beats), 32'd1);
`ifdef CSA_ACCUM_RESOLVE_EN
        check("t3_out_sum", 32'(out_sum), 32'd6);
`endif
        tick();
        check("t3_drained", 32'(out_valid), 32'd0);

        // Test 4: in_first during a partial packet restarts accumulation.
        beat(19'd100, 19'd0, 19'd0, 19'd0, 1'b1, 1'b0);
        check("t4_no_valid", 32'(out_valid), 32'd0);
        beat(19'd7, 19'd0, 19'd0, 19'd0, 1'b1, 1'b1);
        check("t4_sum", 32'(rsum(out_c, out_s)), 32'd7);
        check("t4_beats", 32'(out_beats), 32'd1);
        tick();

        // Test 5: reset in the middle of a packet discards the partial sum.
        beat(19'd10, 19'd10, 19'd10, 19'd20, 1'b1, 1'b0);
        beat(19'd10, 19'd10, 19'd10, 19'd20, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_c", 32'(out_c), 32'd0);
        check("t5_rst_s", 32'(out_s), 32'd0);
        check("t5_rst_beats", 32'(out_beats), 32'd0);
`ifdef CSA_ACCUM_RESOLVE_EN
        check("t5_rst_out_sum", 32'(out_sum), 32'd0);
`endif
        beat(19'd5, 19'd0, 19'd0, 19'd0, 1'b0, 1'b1);
        check("t5_sum", 32'(rsum(out_c, out_s)), 32'd5);
        check("t5_beats", 32'(out_beats), 32'd1);
        tick();

        // Test 6: five beats of ones. The CNT_W=2 instance saturates at 3.
        beat(19'd1, 19'd1, 19'd1, 19'd1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            beat(19'd1, 19'd1, 19'd1, 19'd1, 1'b0, 1'b0);
        end
        beat(19'd1, 19'd1, 19'd1, 19'd1, 1'b0, 1'b1);
        check("t6_sum", 32'(rsum(out_c, out_s)), 32'd20);
        check("t6_beats", 32'(out_beats), 32'd5);
        check("t6_valid2", 32'(out_valid2), 32'd1);
        check("t6_sum2", 32'(rsum(out_c2, out_s2)), 32'd20);
        check("t6_beats2_sat", 32'(out_beats2), 32'd3);
        check("t6_c0_2", 32'(out_c2[0]), 32'd0);
`ifdef CSA_ACCUM_RESOLVE_EN
        check("t6_out_sum2", 32'(out_sum2), 32'd20);
`endif
        tick();
        check("t6_drained2", 32'(out_valid2), 32'd0);
        check("t6_in_ready2", 32'(in_ready2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
